// File: rtl/ctrino_arb_pkg.sv
// Shared types and width helpers for the register-bank write-port arbiters.
package ctrino_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    function automatic int idw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cntw_of(input int m);
        return $clog2(m + 1);
    endfunction

    localparam int NUM_REQ_DFLT   = 4;
    localparam int MAX_BURST_DFLT = 4;
    localparam int IDW            = idw_of(NUM_REQ_DFLT);
    localparam int CNTW           = cntw_of(MAX_BURST_DFLT);

endpackage

// File: rtl/regbank_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index at or above rr_ptr, wrapping.
module rr_pick
    import ctrino_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DFLT,
    parameter int IW      = idw_of(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IW-1:0]      rr_ptr,
    output logic [IW-1:0]      pick,
    output logic               any_valid
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [IW-1:0]        off;
    logic [IW:0]          sum;

    // Rotate so bit 0 is the rr_ptr requester; the lowest set bit is the winner.
    always_comb begin
        dbl       = {req_valid, req_valid} >> rr_ptr;
        rot       = dbl[NUM_REQ-1:0];
        off       = '0;
        any_valid = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off       = IW'(i);
                any_valid = 1'b1;
            end
        end
        sum = {1'b0, rr_ptr} + {1'b0, off};
        if (sum >= (IW+1)'(NUM_REQ)) begin
            sum = sum - (IW+1)'(NUM_REQ);
        end
        pick = sum[IW-1:0];
    end

endmodule

// File: rtl/regbank_wr_arbiter.sv
// Round-robin, burst-locked arbiter for the single write port of the register bank,
// with one registered output stage and valid/ready backpressure from the bank.
module regbank_wr_arbiter
    import ctrino_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_last,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        wr_en,
    output logic [ADDR_W-1:0]           wr_addr,
    output logic [DATA_W-1:0]           wr_data,
    input  logic                        wr_ready,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy
);

    localparam int IW = idw_of(NUM_REQ);
    localparam int CW = cntw_of(MAX_BURST);

    arb_state_t    state, state_next;
    logic [IW-1:0] rr_ptr, rr_ptr_next;
    logic [IW-1:0] owner, owner_next;
    logic [CW-1:0] beat_cnt, beat_cnt_next;
    logic [IW-1:0] pick;
    logic          any_valid;
    logic          out_free;
    logic          accept;

    logic [ADDR_W-1:0] addr_arr [NUM_REQ];
    logic [DATA_W-1:0] data_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
        assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
    end

    rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .pick      (pick),
        .any_valid (any_valid)
    );

    assign grant_id = owner;
    assign busy     = (state == OWN);
    assign out_free = !wr_en || wr_ready;

    always_comb begin
        state_next    = state;
        rr_ptr_next   = rr_ptr;
        owner_next    = owner;
        beat_cnt_next = beat_cnt;
        req_ready     = '0;
        accept        = 1'b0;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    owner_next    = pick;
                    beat_cnt_next = '0;
                    state_next    = OWN;
                end
            end
            OWN: begin
                req_ready[owner] = out_free;
                accept           = req_valid[owner] && out_free;
                if (accept) begin
                    // A mid-burst gap in req_valid keeps the lock; only last or the cap releases it.
                    if (req_last[owner] || beat_cnt == CW'(MAX_BURST - 1)) begin
                        state_next    = IDLE;
                        rr_ptr_next   = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + IW'(1);
                        beat_cnt_next = '0;
                    end else begin
                        beat_cnt_next = beat_cnt + CW'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_next;
            rr_ptr   <= rr_ptr_next;
            owner    <= owner_next;
            beat_cnt <= beat_cnt_next;
        end
    end

    // Output stage: holds its beat while the bank stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (accept) begin
            wr_en   <= 1'b1;
            wr_addr <= addr_arr[owner];
            wr_data <= data_arr[owner];
        end else if (wr_ready) begin
            wr_en   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// Scoreboard bench for regbank_wr_arbiter: directed beats, expected bank writes queued in hand-derived order.
module tb_regbank_wr_arbiter;

    typedef struct packed {
        logic [1:0]  rq;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [19:0] req_addr;
    logic [127:0] req_data;
    logic [3:0]  req_ready;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic [1:0]  grant_id;
    logic        busy;

    logic [4:0]  aa [4];
    logic [31:0] da [4];
    logic [3:0]  gap;
    logic [3:0]  acc;

    beat_t bq [$];
    wr_t   exp_q [$];
    int    acc_cyc [$];
    int    cyc = 0;
    int    tests = 0;
    int    fails = 0;

    assign req_addr = {aa[3], aa[2], aa[1], aa[0]};
    assign req_data = {da[3], da[2], da[1], da[0]};

    regbank_wr_arbiter #(.NUM_REQ(4), .ADDR_W(5), .DATA_W(32), .MAX_BURST(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [4:0] ba(input int rq, input int b);
        return 5'(rq * 8 + b);
    endfunction

    function automatic logic [31:0] bd(input int rq, input int b);
        return 32'hA000_0000 + 32'(rq * 256 + b);
    endfunction

    task automatic add_beat(input int rq, input logic [4:0] a, input logic [31:0] d, input logic l);
        beat_t bt;
        bt.rq = 2'(rq); bt.addr = a; bt.data = d; bt.last = l;
        bq.push_back(bt);
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a; w.data = d;
        exp_q.push_back(w);
    endtask

    task automatic pop_beat(input int rq);
        for (int k = 0; k < bq.size(); k++) begin
            if (int'(bq[k].rq) == rq) begin
                bq.delete(k);
                return;
            end
        end
    endtask

    task automatic apply_drive();
        for (int i = 0; i < 4; i++) begin
            req_valid[i] = 1'b0;
            req_last[i]  = 1'b0;
            aa[i] = '0;
            da[i] = '0;
            for (int k = 0; k < bq.size(); k++) begin
                if (int'(bq[k].rq) == i) begin
                    req_valid[i] = !gap[i];
                    req_last[i]  = bq[k].last;
                    aa[i] = bq[k].addr;
                    da[i] = bq[k].data;
                    break;
                end
            end
        end
    endtask

    // Requester model: pops a beat after the edge that accepted it, redrives at +3.
    initial begin
        gap = '0;
        acc = '0;
        apply_drive();
        forever begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) if (acc[i]) pop_beat(i);
            #2;
            apply_drive();
        end
    end

    // Bank-side monitor: every beat the bank takes must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && wr_en && wr_ready) begin
            acc_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr %0h data %0h, expected none", wr_addr, wr_data);
            end else begin
                chk("wr_beat", {27'd0, wr_addr, wr_data}, {27'd0, exp_q[0].addr, exp_q[0].data});
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (exp_q.size() != 0 && n < 200);
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bq.delete();
        exp_q.delete();
        gap = '0;
        wr_ready = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        wr_ready = 1'b1;
        step();
        @(negedge clk);
        chk("reset_outputs", {17'd0, req_ready, wr_en, wr_addr, wr_data, grant_id, busy}, 64'd0);
        step();

        // Single beat from requester 2.
        do_reset();
        add_beat(2, 5'd5, 32'hDEADBEEF, 1'b1);
        expect_wr(5'd5, 32'hDEADBEEF);
        @(negedge clk);
        chk("single_idle", {req_ready, busy}, {4'b0000, 1'b0});
        step();
        @(negedge clk);
        chk("single_ready", {req_ready, grant_id, busy}, {4'b0100, 2'd2, 1'b1});
        step();
        @(negedge clk);
        chk("single_wr_en", 64'(wr_en), 64'd1);
        drain("single_drain");
        chk("single_rr_ptr", 64'(dut.rr_ptr), 64'd3);

        // Round robin, single-beat grants from everybody.
        do_reset();
        acc_cyc.delete();
        add_beat(0, ba(0, 0), bd(0, 0), 1'b1);
        add_beat(0, ba(0, 1), bd(0, 1), 1'b1);
        add_beat(1, ba(1, 0), bd(1, 0), 1'b1);
        add_beat(2, ba(2, 0), bd(2, 0), 1'b1);
        add_beat(3, ba(3, 0), bd(3, 0), 1'b1);
        expect_wr(ba(0, 0), bd(0, 0));
        expect_wr(ba(1, 0), bd(1, 0));
        expect_wr(ba(2, 0), bd(2, 0));
        expect_wr(ba(3, 0), bd(3, 0));
        expect_wr(ba(0, 1), bd(0, 1));
        drain("rr_drain");
        for (int k = 0; k < 4; k++) begin
            if (acc_cyc.size() > k + 1) chk("rr_spacing", 64'(acc_cyc[k+1] - acc_cyc[k]), 64'd2);
            else chk("rr_count", 64'(acc_cyc.size()), 64'd5);
        end

        // Burst cap: requester 1 never sends last.
        do_reset();
        acc_cyc.delete();
        for (int b = 0; b < 6; b++) add_beat(1, ba(1, b), bd(1, b), 1'b0);
        add_beat(3, ba(3, 0), bd(3, 0), 1'b1);
        for (int b = 0; b < 4; b++) expect_wr(ba(1, b), bd(1, b));
        expect_wr(ba(3, 0), bd(3, 0));
        expect_wr(ba(1, 4), bd(1, 4));
        expect_wr(ba(1, 5), bd(1, 5));
        drain("cap_drain");
        begin
            int sp [6] = '{1, 1, 1, 2, 2, 1};
            for (int k = 0; k < 6; k++) begin
                if (acc_cyc.size() > k + 1) chk("cap_spacing", 64'(acc_cyc[k+1] - acc_cyc[k]), 64'(sp[k]));
                else chk("cap_count", 64'(acc_cyc.size()), 64'd7);
            end
        end
        @(negedge clk);
        chk("cap_lock_held", {busy, grant_id}, {1'b1, 2'd1});

        // Backpressure: bank stalls three cycles with the second beat on the port.
        do_reset();
        for (int b = 0; b < 4; b++) begin
            add_beat(0, ba(0, b), bd(0, b), b == 3);
            expect_wr(ba(0, b), bd(0, b));
        end
        step();
        step();
        step();
        wr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_hold", {wr_en, wr_addr, wr_data}, {1'b1, ba(0, 1), bd(0, 1)});
            chk("bp_ready", {req_ready, busy}, {4'b0000, 1'b1});
            chk("bp_cnt", 64'(dut.beat_cnt), 64'd2);
            step();
        end
        wr_ready = 1'b1;
        drain("bp_drain");

        // Owner gap: requester 2 pauses while 0 and 1 wait.
        do_reset();
        for (int b = 0; b < 3; b++) begin
            add_beat(2, ba(2, b), bd(2, b), b == 2);
            expect_wr(ba(2, b), bd(2, b));
        end
        step();
        step();
        gap[2] = 1'b1;
        add_beat(0, ba(0, 0), bd(0, 0), 1'b1);
        add_beat(1, ba(1, 0), bd(1, 0), 1'b1);
        expect_wr(ba(0, 0), bd(0, 0));
        expect_wr(ba(1, 0), bd(1, 0));
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("gap_lock", {req_ready, grant_id, busy}, {4'b0100, 2'd2, 1'b1});
            step();
        end
        gap[2] = 1'b0;
        drain("gap_drain");

        // Asynchronous reset in the middle of a burst from requester 3.
        do_reset();
        for (int b = 0; b < 4; b++) begin
            add_beat(3, ba(3, b), bd(3, b), b == 3);
            expect_wr(ba(3, b), bd(3, b));
        end
        step();
        step();
        step();
        #5;
        reset = 1'b1;
        #1;
        chk("areset_clear", {req_ready, wr_en, busy}, {4'b0000, 1'b0, 1'b0});
        bq.delete();
        exp_q.delete();
        step();
        step();
        add_beat(3, ba(3, 4), bd(3, 4), 1'b1);
        add_beat(0, ba(0, 2), bd(0, 2), 1'b1);
        expect_wr(ba(0, 2), bd(0, 2));
        expect_wr(ba(3, 4), bd(3, 4));
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("areset_idle", {req_ready, busy}, {4'b0000, 1'b0});
        step();
        @(negedge clk);
        chk("areset_first_grant", {req_ready, grant_id, busy}, {4'b0001, 2'd0, 1'b1});
        drain("areset_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/regbank_wr_arbiter.md
Name: regbank_wr_arbiter

Overview:
- Shares the single write port of the core's flop-based register bank among NUM_REQ requesters.
- Requesters include writeback, load return, CSR unit and debug.
- Round-robin arbitration with burst locking: an owner keeps the port until its last beat or MAX_BURST beats.
- Output is one registered stage driving the bank, with valid/ready backpressure from the bank side.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 5, register address width
DATA_W, 32, register data width
MAX_BURST, 4, max beats per grant before forced release (1..16)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester beat valid
req_last  in  NUM_REQ  beat is last of requester's burst
req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_data  in  NUM_REQ*DATA_W  packed data, same packing
req_ready  out  NUM_REQ  per-requester beat accepted this cycle (one-hot or zero)
wr_en  out  1  write valid to register bank
wr_addr  out  ADDR_W  write address
wr_data  out  DATA_W  write data
wr_ready  in  1  bank accepts the wr_* beat this cycle
grant_id  out  clog2(NUM_REQ)  current owner index
busy  out  1  high while in OWN state

Behaviour:
- Reset (async, immediate):
  - state=IDLE, rr_ptr=0, owner=0, beat_cnt=0.
  - wr_en=0, wr_addr=0, wr_data=0, req_ready=0, grant_id=0, busy=0.
  - Any in-flight beat in the output register is discarded.
- States are IDLE and OWN.
- IDLE:
  - req_ready=0.
  - If any req_valid is high, pick the first valid index searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - At the clock edge: owner<=pick, grant_id<=pick, beat_cnt<=0, state<=OWN.
  - Arbitration costs exactly one cycle: a valid first seen in cycle N can be accepted at the earliest in cycle N+1.
- OWN:
  - out_free = !wr_en || wr_ready.
  - req_ready[owner] = out_free. All other req_ready bits are 0.
  - accept = req_valid[owner] && req_ready[owner].
- On accept:
  - wr_en<=1, wr_addr<=req_addr[owner], wr_data<=req_data[owner].
  - If req_last[owner] or beat_cnt==MAX_BURST-1: state<=IDLE, rr_ptr<=(owner+1) mod NUM_REQ, beat_cnt<=0.
  - Otherwise beat_cnt<=beat_cnt+1.
- Without accept: if wr_ready, wr_en<=0. wr_addr and wr_data hold their values.
- Latency: an accepted beat in cycle N appears on wr_* in cycle N+1.
- Throughput: one beat per cycle while wr_ready=1.
- Backpressure from the bank:
  - wr_en with wr_ready=0 holds wr_en, wr_addr and wr_data stable.
  - req_ready stays 0 until the bank accepts.
  - No beat is ever dropped or duplicated.
- Owner deasserts req_valid mid-burst: the lock is held, state stays OWN, beat_cnt is unchanged. There is no timeout; requesters must complete their bursts.
- Forced release at MAX_BURST:
  - The owner loses the grant even with req_last=0.
  - It must re-arbitrate and resumes after other valid requesters get a turn.
- rr_ptr wrap: owner NUM_REQ-1 releasing sets rr_ptr=0.
- Simultaneous events:
  - A requester's valid rising in the same cycle as a release is seen by the next IDLE cycle.
  - The releasing owner has lowest priority in that IDLE cycle, because rr_ptr has already advanced.
- Reset asserted mid-burst: everything clears asynchronously; the next arbitration starts from rr_ptr=0.
- Width rule: beat_cnt is clog2(MAX_BURST+1) bits and never exceeds MAX_BURST-1.

Decomposition:
- Package ctrino_arb_pkg:
  - arb_state_t enum {IDLE, OWN}.
  - Width constants derived via $clog2: IDW for grant/owner width, CNTW for beat counter width.
- One sub-module, rr_pick: combinational.
  - Inputs: req_valid vector and rr_ptr.
  - Outputs: pick index and any_valid.
  - Reusable for future read-port arbiters.

Test Plan:
- Single beat: reset, then req_valid[2]=1, req_last[2]=1, addr=5, data=0xDEADBEEF, wr_ready=1 -> idle in cycle 1, req_ready[2]=1 in cycle 2, wr_en=1 with addr=5 and data=0xDEADBEEF in cycle 3, rr_ptr=3.
- Round robin: all four req_valid high, every beat has req_last=1 -> grant order 0,1,2,3,0, each followed by one IDLE cycle.
- Burst cap: MAX_BURST=4, requester 1 streams 6 beats with req_last=0 and requester 3 also valid -> 4 beats from 1, then 3 is granted, then 1 resumes.
- Backpressure: wr_ready=0 for 3 cycles mid-burst -> wr_* held stable, req_ready[owner]=0, beat count intact, no beat lost or duplicated.
- Owner gap: owner drops valid for 2 cycles mid-burst while others are valid -> busy=1, grant_id unchanged, no other req_ready asserted.
- Async reset: assert reset between clock edges mid-burst -> wr_en, req_ready and busy go to 0 immediately; after release, requester 0 wins the first arbitration.
